// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM encoding, parity modes, frame length.
package uart_pkg;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_START      = 3'd1;
  localparam logic [2:0] S_DATA       = 3'd2;
  localparam logic [2:0] S_PARITY     = 3'd3;
  localparam logic [2:0] S_STOP       = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;
  localparam logic [2:0] S_BREAK_WAIT = 3'd6;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Start bit + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity_en, input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser plus 3-sample majority voter around the bit midpoint.
// Vote is combinational at count == mid+1 using samples taken at mid-1, mid and the current rx_s.
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             i_Clock,
  input  logic             i_Rst_L,
  input  logic             rx,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] mid,
  output logic             rx_s,
  output logic             vote_valid,
  output logic             vote
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   samp_a;
  logic                   samp_b;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync   <= '1;
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      if (count == mid - CNT_W'(1)) samp_a <= rx_s;
      if (count == mid)             samp_b <= rx_s;
    end
  end

  assign rx_s       = sync[SYNC_STAGES-1];
  assign vote_valid = (count == mid + CNT_W'(1));
  assign vote       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5-9 data bits, optional parity, 1-2 stop bits, break detect).
// o_RX_DV pulses ~MID+2+SYNC_STAGES cycles into the final stop bit; no backpressure, consumer must take each pulse.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);
  import uart_pkg::*;

  localparam int CW         = $clog2(CLKS_PER_BIT);
  localparam int MID_I      = (CLKS_PER_BIT - 1) / 2;
  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_EN, STOP_BITS);

  localparam logic [CW-1:0] MID        = CW'(MID_I);
  localparam logic [CW-1:0] LAST_CNT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA  = 4'(DATA_BITS);
  localparam logic [3:0]    FIRST_STOP = 4'(1 + DATA_BITS + PARITY_EN);
  localparam logic [3:0]    LAST_STOP  = 4'(FRAME_BITS - 1);
  localparam logic [1:0]    PAR_MODE   = (PARITY_EN == 0) ? PAR_NONE :
                                         (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [CW-1:0]        cnt;
  logic [3:0]           pos;
  logic [DATA_BITS-1:0] shreg;
  logic                 parity_err;
  logic                 frame_err;
  logic                 par_zero;
  logic                 stop0_zero;
  logic                 rx_s;
  logic                 vote_valid;
  logic                 vote;
  logic                 par_exp;
  logic                 brk_now;
  logic                 frame_err_now;

  uart_rx_sampler #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CW)
  ) u_sampler (
    .i_Clock    (i_Clock),
    .i_Rst_L    (i_Rst_L),
    .rx         (i_RX_Serial),
    .count      (cnt),
    .mid        (MID),
    .rx_s       (rx_s),
    .vote_valid (vote_valid),
    .vote       (vote)
  );

  assign o_Busy = (state != S_IDLE);

  // Break needs the first stop vote; with one stop bit that is the vote being taken right now.
  always_comb begin
    par_exp       = (^shreg) ^ (PAR_MODE == PAR_ODD);
    brk_now       = (shreg == '0) && ((PARITY_EN == 0) || par_zero) &&
                    ((pos == FIRST_STOP) ? !vote : stop0_zero);
    frame_err_now = frame_err | !vote;
    state_nxt     = state;
    case (state)
      S_IDLE:       if (!rx_s) state_nxt = S_START;
      S_START:      if (vote_valid) state_nxt = vote ? S_IDLE : S_DATA;
      S_DATA:       if (vote_valid && pos == LAST_DATA)
                      state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY:     if (vote_valid) state_nxt = S_STOP;
      S_STOP:       if (vote_valid && pos == LAST_STOP) state_nxt = S_DONE;
      S_DONE:       state_nxt = o_Break ? S_BREAK_WAIT : S_IDLE;
      S_BREAK_WAIT: if (rx_s) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Counter free-runs modulo CLKS_PER_BIT from START entry, so every bit's vote lands at MID+1.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state        <= S_IDLE;
      cnt          <= '0;
      pos          <= '0;
      shreg        <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      par_zero     <= 1'b0;
      stop0_zero   <= 1'b0;
      o_RX_DV      <= 1'b0;
      o_RX_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_RX_DV <= 1'b0;
      if (state == S_IDLE) cnt <= '0;
      else                 cnt <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
      case (state)
        S_IDLE: if (!rx_s) begin
          pos        <= '0;
          shreg      <= '0;
          parity_err <= 1'b0;
          frame_err  <= 1'b0;
          par_zero   <= 1'b0;
          stop0_zero <= 1'b0;
        end
        S_START: if (vote_valid && !vote) pos <= 4'd1;
        S_DATA: if (vote_valid) begin
          shreg <= {vote, shreg[DATA_BITS-1:1]};
          pos   <= pos + 4'd1;
        end
        S_PARITY: if (vote_valid) begin
          if (vote != par_exp) parity_err <= 1'b1;
          par_zero <= !vote;
          pos      <= pos + 4'd1;
        end
        S_STOP: if (vote_valid) begin
          if (pos == FIRST_STOP) stop0_zero <= !vote;
          if (!vote) frame_err <= 1'b1;
          pos <= pos + 4'd1;
          if (pos == LAST_STOP) begin
            o_RX_DV      <= 1'b1;
            o_RX_Byte    <= brk_now ? '0 : shreg;
            o_Parity_Err <= parity_err;
            o_Frame_Err  <= frame_err_now | brk_now;
            o_Break      <= brk_now;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three configurations (8N1, 8E1, 7O2) at 16 clocks per bit.
module tb_uart_rx_cfg;
  localparam int CPB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a  = 1'b1;
  logic rx_b  = 1'b1;
  logic rx_c  = 1'b1;

  logic       dv_a, perr_a, ferr_a, brk_a, busy_a;
  logic [7:0] byte_a;
  logic       dv_b, perr_b, ferr_b, brk_b, busy_b;
  logic [7:0] byte_b;
  logic       dv_c, perr_c, ferr_c, brk_c, busy_c;
  logic [6:0] byte_c;

  int n_cmp = 0;
  int n_bad = 0;
  int dvcnt_a = 0;
  int dvcnt_b = 0;
  int dvcnt_c = 0;
  logic [7:0] q_a[$];

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_8n1 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx_a), .o_RX_DV(dv_a), .o_RX_Byte(byte_a),
    .o_Parity_Err(perr_a), .o_Frame_Err(ferr_a), .o_Break(brk_a), .o_Busy(busy_a));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_8e1 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx_b), .o_RX_DV(dv_b), .o_RX_Byte(byte_b),
    .o_Parity_Err(perr_b), .o_Frame_Err(ferr_b), .o_Break(brk_b), .o_Busy(busy_b));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .SYNC_STAGES(2)) u_7o2 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx_c), .o_RX_DV(dv_c), .o_RX_Byte(byte_c),
    .o_Parity_Err(perr_c), .o_Frame_Err(ferr_c), .o_Break(brk_c), .o_Busy(busy_c));

  always @(negedge clk) begin
    if (dv_a === 1'b1) begin
      dvcnt_a++;
      q_a.push_back(byte_a);
    end
    if (dv_b === 1'b1) dvcnt_b++;
    if (dv_c === 1'b1) dvcnt_c++;
  end

  task automatic set_line(input int which, input logic v);
    case (which)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame bits LSB first (bit 0 = start bit); optional one-cycle inversion mid-way through one bit.
  task automatic drive_frame(input int which, input logic [31:0] f, input int len, input int glitch_bit);
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        set_line(which, (i == glitch_bit && c == 8) ? ~f[i] : f[i]);
      end
    end
    @(negedge clk);
    set_line(which, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_cmp++;
    if ({dv_a, byte_a, perr_a, ferr_a, brk_a, busy_a} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_8n1: got %b want 0", {dv_a, byte_a, perr_a, ferr_a, brk_a, busy_a});
    end
    n_cmp++;
    if ({dv_c, byte_c, perr_c, ferr_c, brk_c, busy_c} !== 12'd0) begin
      n_bad++;
      $display("FAIL reset_7o2: got %b want 0", {dv_c, byte_c, perr_c, ferr_c, brk_c, busy_c});
    end
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_8n1();
    int base;
    base = dvcnt_a;
    drive_frame(0, {22'b0, 1'b1, 8'hA5, 1'b0}, 10, -1);
    idle(2);
    n_cmp++;
    if (dvcnt_a - base !== 1) begin n_bad++; $display("FAIL 8n1_dv_count: got %0d want 1", dvcnt_a - base); end
    n_cmp++;
    if (byte_a !== 8'hA5) begin n_bad++; $display("FAIL 8n1_byte: got %h want a5", byte_a); end
    n_cmp++;
    if ({perr_a, ferr_a, brk_a} !== 3'b000) begin n_bad++; $display("FAIL 8n1_flags: got %b want 000", {perr_a, ferr_a, brk_a}); end
    n_cmp++;
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL 8n1_busy_low: got %b want 0", busy_a); end
  endtask

  task automatic test_parity_even();
    int base;
    base = dvcnt_b;
    drive_frame(1, {21'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1);
    idle(4);
    n_cmp++;
    if (dvcnt_b - base !== 1) begin n_bad++; $display("FAIL 8e1_good_dv: got %0d want 1", dvcnt_b - base); end
    n_cmp++;
    if ({byte_b, perr_b, ferr_b} !== {8'h07, 2'b00}) begin
      n_bad++; $display("FAIL 8e1_good: got byte %h perr %b ferr %b want 07 0 0", byte_b, perr_b, ferr_b);
    end
    base = dvcnt_b;
    drive_frame(1, {21'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1);
    idle(4);
    n_cmp++;
    if (dvcnt_b - base !== 1) begin n_bad++; $display("FAIL 8e1_bad_dv: got %0d want 1", dvcnt_b - base); end
    n_cmp++;
    if ({byte_b, perr_b, ferr_b} !== {8'h07, 2'b10}) begin
      n_bad++; $display("FAIL 8e1_bad: got byte %h perr %b ferr %b want 07 1 0", byte_b, perr_b, ferr_b);
    end
  endtask

  task automatic test_stop2_frame_err();
    int base;
    base = dvcnt_c;
    drive_frame(2, {21'b0, 1'b0, 1'b1, 1'b1, 7'h55, 1'b0}, 11, -1);
    idle(40);
    n_cmp++;
    if (dvcnt_c - base !== 1) begin n_bad++; $display("FAIL 7o2_dv: got %0d want 1", dvcnt_c - base); end
    n_cmp++;
    if (byte_c !== 7'h55) begin n_bad++; $display("FAIL 7o2_byte: got %h want 55", byte_c); end
    n_cmp++;
    if ({perr_c, ferr_c, brk_c} !== 3'b010) begin
      n_bad++; $display("FAIL 7o2_flags: got perr/ferr/brk %b want 010", {perr_c, ferr_c, brk_c});
    end
  endtask

  task automatic test_glitch();
    int base;
    base = dvcnt_a;
    rx_a = 1'b0;
    idle(3);
    rx_a = 1'b1;
    idle(40);
    n_cmp++;
    if ({dvcnt_a - base, busy_a} !== {32'd0, 1'b0}) begin
      n_bad++; $display("FAIL idle_glitch: got dv %0d busy %b want 0 0", dvcnt_a - base, busy_a);
    end
    base = dvcnt_a;
    drive_frame(0, {22'b0, 1'b1, 8'h3C, 1'b0}, 10, 3);
    idle(2);
    n_cmp++;
    if (dvcnt_a - base !== 1) begin n_bad++; $display("FAIL data_glitch_dv: got %0d want 1", dvcnt_a - base); end
    n_cmp++;
    if ({byte_a, ferr_a} !== {8'h3C, 1'b0}) begin
      n_bad++; $display("FAIL data_glitch_byte: got %h ferr %b want 3c 0", byte_a, ferr_a);
    end
  endtask

  task automatic test_break();
    int base;
    base = dvcnt_a;
    rx_a = 1'b0;
    idle(20 * CPB);
    n_cmp++;
    if (dvcnt_a - base !== 1) begin n_bad++; $display("FAIL break_dv: got %0d want 1", dvcnt_a - base); end
    n_cmp++;
    if ({byte_a, brk_a, ferr_a, busy_a} !== {8'h00, 3'b111}) begin
      n_bad++; $display("FAIL break_out: got byte %h brk %b ferr %b busy %b want 00 1 1 1", byte_a, brk_a, ferr_a, busy_a);
    end
    rx_a = 1'b1;
    idle(2 * CPB);
    n_cmp++;
    if ({dvcnt_a - base, busy_a} !== {32'd1, 1'b0}) begin
      n_bad++; $display("FAIL break_release: got dv %0d busy %b want 1 0", dvcnt_a - base, busy_a);
    end
    drive_frame(0, {22'b0, 1'b1, 8'h81, 1'b0}, 10, -1);
    idle(2);
    n_cmp++;
    if ({dvcnt_a - base, byte_a, brk_a, ferr_a} !== {32'd2, 8'h81, 2'b00}) begin
      n_bad++; $display("FAIL after_break: got dv %0d byte %h brk %b ferr %b want 2 81 0 0", dvcnt_a - base, byte_a, brk_a, ferr_a);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    base = dvcnt_a;
    drive_frame(0, 32'h0, 5, -1);
    idle(7);
    rst_n = 1'b0;
    idle(1);
    n_cmp++;
    if ({dv_a, byte_a, perr_a, ferr_a, brk_a, busy_a} !== 13'd0) begin
      n_bad++; $display("FAIL midframe_reset_out: got %b want 0", {dv_a, byte_a, perr_a, ferr_a, brk_a, busy_a});
    end
    idle(3);
    rst_n = 1'b1;
    idle(3 * CPB);
    n_cmp++;
    if (dvcnt_a - base !== 0) begin n_bad++; $display("FAIL midframe_no_dv: got %0d want 0", dvcnt_a - base); end
  endtask

  task automatic test_back_to_back();
    int base;
    q_a.delete();
    base = dvcnt_a;
    drive_frame(0, {12'b0, 1'b1, 8'h34, 1'b0, 1'b1, 8'h12, 1'b0}, 20, -1);
    idle(2);
    n_cmp++;
    if ({dvcnt_a - base, q_a.size()} !== {32'd2, 32'd2}) begin
      n_bad++; $display("FAIL b2b_count: got %0d pulses want 2", dvcnt_a - base);
    end
    n_cmp++;
    if (q_a[0] !== 8'h12) begin n_bad++; $display("FAIL b2b_first: got %h want 12", q_a[0]); end
    n_cmp++;
    if (q_a[1] !== 8'h34) begin n_bad++; $display("FAIL b2b_second: got %h want 34", q_a[1]); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity_even();
    test_stop2_frame_err();
    test_glitch();
    test_break();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
